// File: rtl/score_pkg.sv
// Shared score definitions: the scorer and the seven-segment score display both
// import this so they agree on the width and meaning of a score.
package score_pkg;

    // 0 = best (green) .. 7 = worst (red)
    typedef logic [2:0] score_t;

    localparam score_t SCORE_MIN = 3'd0;
    localparam score_t SCORE_MAX = 3'd7;

    // ACCUM gathers samples; QUANT turns a finished window into a score.
    typedef enum logic {
        ACCUM = 1'b0,
        QUANT = 1'b1
    } scorer_state_t;

endpackage : score_pkg

// File: rtl/score_quantizer.sv
// Combinational window-sum to score conversion. The window sum is averaged by a
// power-of-two shift, divided into bins of 2^BIN_SHIFT error units, and any bin
// past the worst score saturates there.
module score_quantizer
    import score_pkg::*;
#(
    parameter int SUM_WIDTH   = 22,
    parameter int LOG2_WINDOW = 6,
    parameter int BIN_SHIFT   = 8
) (
    input  logic [SUM_WIDTH-1:0] window_sum,
    output score_t               score
);

    logic [SUM_WIDTH-1:0] avg_s;
    logic [SUM_WIDTH-1:0] bin_s;

    // Average the window, pick its bin and clamp it to the score range.
    always_comb begin
        avg_s = window_sum >> LOG2_WINDOW;
        bin_s = avg_s >> BIN_SHIFT;
        if (bin_s > SUM_WIDTH'(SCORE_MAX)) begin
            score = SCORE_MAX;
        end else begin
            score = bin_s[2:0];
        end
    end

endmodule : score_quantizer

// File: rtl/error_scorer.sv
// Error scorer: averages per-sample error magnitudes over fixed windows,
// quantizes each window average into a 0..7 score, and presents a new score
// only at a frame boundary so the on-screen score sprite never tears.
module error_scorer
    import score_pkg::*;
#(
    parameter int ERR_WIDTH   = 16,
    parameter int LOG2_WINDOW = 6,
    parameter int BIN_SHIFT   = 8
) (
    input  logic                 clk_in,
    input  logic                 rst_in,
    input  logic [ERR_WIDTH-1:0] err_in,
    input  logic                 err_valid_in,
    input  logic                 frame_start_in,
    output score_t               score_out,
    output logic                 score_update_out,
    output logic                 window_done_out
);

    // A full window of maximum-magnitude samples fits exactly in SUM_WIDTH bits.
    localparam int SUM_WIDTH = ERR_WIDTH + LOG2_WINDOW;
    localparam int CNT_WIDTH = LOG2_WINDOW + 1;
    localparam logic [CNT_WIDTH-1:0] LAST_COUNT = CNT_WIDTH'((1 << LOG2_WINDOW) - 1);

    scorer_state_t          state_r;
    logic [SUM_WIDTH-1:0]   sum_r;
    logic [CNT_WIDTH-1:0]   count_r;
    logic [SUM_WIDTH-1:0]   window_sum_r;
    logic                   window_done_r;
    score_t                 pending_score_r;
    logic                   pending_valid_r;
    score_t                 score_r;
    logic                   score_update_r;

    logic [SUM_WIDTH-1:0]   sum_next_s;
    logic                   apply_pending_s;
    score_t                 quant_score_s;

    score_quantizer #(
        .SUM_WIDTH   (SUM_WIDTH),
        .LOG2_WINDOW (LOG2_WINDOW),
        .BIN_SHIFT   (BIN_SHIFT)
    ) u_quantizer (
        .window_sum (window_sum_r),
        .score      (quant_score_s)
    );

    // Running sum including the current sample, and the frame-boundary apply condition.
    always_comb begin
        sum_next_s      = sum_r + SUM_WIDTH'(err_in);
        apply_pending_s = frame_start_in && pending_valid_r;
    end

    // Window accumulation FSM; QUANT lasts one cycle and still accepts a sample
    // (into the fresh window) so no valid sample is ever dropped.
    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            state_r       <= ACCUM;
            sum_r         <= {SUM_WIDTH{1'b0}};
            count_r       <= {CNT_WIDTH{1'b0}};
            window_sum_r  <= {SUM_WIDTH{1'b0}};
            window_done_r <= 1'b0;
        end else begin
            case (state_r)
                ACCUM: begin
                    window_done_r <= 1'b0;
                    if (err_valid_in) begin
                        if (count_r == LAST_COUNT) begin
                            window_sum_r <= sum_next_s;
                            sum_r        <= {SUM_WIDTH{1'b0}};
                            count_r      <= {CNT_WIDTH{1'b0}};
                            state_r      <= QUANT;
                        end else begin
                            sum_r   <= sum_next_s;
                            count_r <= count_r + CNT_WIDTH'(1);
                        end
                    end
                end
                QUANT: begin
                    window_done_r <= 1'b1;
                    state_r       <= ACCUM;
                    if (err_valid_in) begin
                        sum_r   <= sum_next_s;
                        count_r <= count_r + CNT_WIDTH'(1);
                    end
                end
                default: begin
                    state_r       <= ACCUM;
                    sum_r         <= {SUM_WIDTH{1'b0}};
                    count_r       <= {CNT_WIDTH{1'b0}};
                    window_done_r <= 1'b0;
                end
            endcase
        end
    end

    // Pending result and displayed score. A result quantized in the same cycle as
    // a frame start becomes pending while the older pending value is displayed.
    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            pending_score_r <= SCORE_MIN;
            pending_valid_r <= 1'b0;
            score_r         <= SCORE_MIN;
            score_update_r  <= 1'b0;
        end else begin
            score_update_r <= apply_pending_s;
            if (apply_pending_s) begin
                score_r <= pending_score_r;
            end
            if (state_r == QUANT) begin
                pending_score_r <= quant_score_s;
                pending_valid_r <= 1'b1;
            end else if (apply_pending_s) begin
                pending_valid_r <= 1'b0;
            end
        end
    end

    assign score_out        = score_r;
    assign score_update_out = score_update_r;
    assign window_done_out  = window_done_r;

endmodule : error_scorer

// File: doc/error_scorer.md
Name: error_scorer

Overview:
- Produces the 3-bit `score` consumed by the seven-segment score display: 0 = best (green), 7 = worst (red).
- Averages a stream of per-sample error magnitudes over a fixed power-of-two window, then quantizes the average into 8 saturating bins.
- Updates the displayed score only at a frame boundary, so the sprite never changes mid-frame (no tearing).
- Sits between the error-measurement pipeline and the video mux's score overlay.

Parameters:
- ERR_WIDTH, 16, width of the unsigned error sample.
- LOG2_WINDOW, 6, log2 of samples per averaging window (default 64).
- BIN_SHIFT, 8, log2 of the error range per score bin (bin = avg >> BIN_SHIFT).

Ports:
- clk_in  input  1  system clock.
- rst_in  input  1  synchronous, active-low reset.
- err_in  input  ERR_WIDTH  unsigned error magnitude.
- err_valid_in  input  1  err_in is valid this cycle. There is no backpressure; every valid sample is accepted.
- frame_start_in  input  1  one-cycle pulse at the start of each video frame.
- score_out  output  3  displayed score, held stable for a whole frame.
- score_update_out  output  1  one-cycle pulse in the cycle score_out takes a new value.
- window_done_out  output  1  one-cycle pulse when a window's result is quantized.

Behaviour:
- Reset: rst_in == 0 at a rising edge clears everything:
  - score_out=0, score_update_out=0, window_done_out=0.
  - sum=0, count=0, pending_valid=0, pending_score=0.
  - state=ACCUM.
  - Reset asserted mid-window discards the partial window.
- Accumulator:
  - sum is ERR_WIDTH+LOG2_WINDOW bits and can never overflow.
  - count is LOG2_WINDOW+1 bits.
- FSM, two states:
  - ACCUM: on err_valid_in, sum+=err_in and count+=1. When the accepted sample is the 2^LOG2_WINDOW-th:
    - latch sum+err_in into window_sum;
    - clear sum and count in the same edge;
    - go to QUANT.
  - QUANT (exactly 1 cycle):
    - avg = window_sum >> LOG2_WINDOW.
    - bin = avg >> BIN_SHIFT, saturated to 7 if ≥ 8.
    - Register pending_score=bin and pending_valid=1; pulse window_done_out; return to ACCUM.
    - A valid sample arriving in the QUANT cycle is accumulated into the new window (no sample ever dropped).
- Latency: 2^LOG2_WINDOW-th sample accepted at edge t → window_done_out high and pending_valid visible in cycle t+2.
- Display update:
  - On frame_start_in with pending_valid==1, the next edge sets score_out=pending_score, pulses score_update_out and clears pending_valid.
  - frame_start_in with pending_valid==0 does nothing; score_out holds.
  - score_update_out pulses even if the new value equals the old one.
- Boundary cases:
  - Multiple windows completing before a frame_start: latest pending_score overwrites earlier ones (latest wins).
  - frame_start_in in the same cycle as a window's last sample, or during QUANT: the new result is not yet pending, so it is not applied; it is applied at the following frame_start_in.
  - frame_start_in in the same cycle a new pending is registered: the old pending_score is applied and the new one becomes pending (pending_valid stays 1).
- All outputs are registered; there are no combinational paths from input to output.

Decomposition:
- Shared package score_pkg:
  - typedef score_t (logic [2:0]);
  - SCORE_MIN=0, SCORE_MAX=7;
  - enum scorer_state_t {ACCUM, QUANT}.
  - The score display imports score_t so both ends agree on width and meaning.
- One combinational sub-module, score_quantizer: window_sum → saturated score_t, parameterized by LOG2_WINDOW and BIN_SHIFT. It is reusable by any future scorer.

Test Plan:
- Reset: hold rst_in=0 for 3 cycles with err_valid_in=1, err_in=0xFFFF → score_out=0, no pulses; after release, the first window starts from count 0.
- Nominal: 64 samples of 0x0300, then frame_start_in → window_done_out 2 cycles after the last sample; score_out=3 with a score_update_out pulse one cycle after frame_start_in.
- Saturation: 64 samples of 0xFFFF then frame_start_in → score_out=7. Also 64 samples of 0x07FF → score_out=7 (avg>>8=7 exactly).
- Latest wins: a window of 0x0200 then a window of 0x0500, no frame_start between, then frame_start_in → score_out=5; exactly one score_update_out pulse.
- Simultaneous: frame_start_in coincident with the 64th sample of 0x0400 → score_out unchanged at that frame; next frame_start_in → score_out=4.
- Reset mid-window: 40 samples of 0xFFFF, rst_in=0 for 1 cycle, then 64 samples of 0x0100 and frame_start_in → score_out=1. This proves the partial sum was discarded.
